fpu_cmd_seq: RTL and testbench
==============================

Name: fpu_cmd_seq

Overview:
Command sequencer that drives the single-precision FPU top: the initiator side of its opcode/act/done interface. Accepts tagged operation requests over a valid/ready port and buffers them in a small FIFO. Issues each request to the FPU with a reset-then-activate sequence, waits for done, then returns the result and exception flags over a valid/ready response port. Sits between a core/CSR front end and the FPU instance.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of the request tag echoed in the response
RST_CYC, 2, cycles fpu_rst is held high before act (>=1)
TIMEOUT, 64, watchdog limit in cycles (used only with FPU_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  request valid
cmd_ready  out  1  FIFO not full
cmd_op  in  3  0 add, 1 mul, 2 div, 3 sqrt, 4 compare
cmd_a, cmd_b  in  32  operands (cmd_b ignored for sqrt)
cmd_rm  in  3  rounding mode
cmd_tag  in  TAG_W  request tag
fpu_in1, fpu_in2  out  32  FPU operands
fpu_opcode  out  3  FPU opcode
fpu_round_m  out  3  FPU rounding mode
fpu_rst  out  1  FPU reset (rstp)
fpu_act  out  1  FPU activate
fpu_out  in  32  FPU result
fpu_flags  in  8  {ov,un,inv,inexact,div_zero,less,eq,great}
fpu_done  in  1  FPU done
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_data  out  32  result (0 for compare)
rsp_flags  out  8  same packing as fpu_flags
rsp_tag  out  TAG_W  echoed tag
rsp_timeout  out  1  watchdog fired (0 when feature absent)
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Clock clk; reset rst is synchronous, active-high. In reset: FIFO empty, FSM IDLE, all outputs 0 except cmd_ready=1. fpu_rst=1 while rst=1.
- FIFO: push on cmd_valid&cmd_ready. Pop on IDLE->RESET. Simultaneous push/pop on a full FIFO is not allowed: cmd_ready depends only on count<DEPTH. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the operand/op/rm/tag holding registers. If op<=4 go RESET. If op>4 go HOLD with rsp_data=0 and rsp_flags=8'b0010_0000 (inv only), no FPU access.
  - RESET: fpu_rst=1, fpu_act=0, for RST_CYC cycles (counter), then RUN.
  - RUN: fpu_act=1. fpu_done is ignored in the first RUN cycle (stale-done guard). On a later cycle with fpu_done=1, capture fpu_out and fpu_flags into rsp regs and go HOLD. For op 4, rsp_data is forced to 0.
  - HOLD: rsp_valid=1, fpu_act=0. On rsp_ready go IDLE; the next command may pop in that same IDLE cycle (no extra bubble beyond the IDLE cycle).
- fpu_in1/in2/opcode/round_m are driven from the holding registers and stay stable from RESET through RUN. They are driven 0 in IDLE and HOLD.
- Response regs hold while rsp_valid=1 and rsp_ready=0.
- Minimum latency from pop to rsp_valid: 1 (IDLE) + RST_CYC + 2 cycles, plus the FPU compute time.
- rst mid-operation: FSM to IDLE immediately; the in-flight command and the FIFO contents are discarded. No response is produced.

Optional Feature:
FPU_TIMEOUT_EN:
- Defined: an 8-bit+ watchdog counts RUN cycles. On reaching TIMEOUT without done, go HOLD with rsp_timeout=1, rsp_data=32'h7FC00000, rsp_flags=inv only, and pulse fpu_rst for one cycle on the HOLD entry.
- Undefined: RUN waits indefinitely and rsp_timeout is tied 0.

Decomposition:
- Shared package fpu_pkg: opcode localparams (OP_ADD=0, OP_MUL=1, OP_DIV=2, OP_SQRT=3, OP_CMP=4), flag bit index constants, FSM state encoding, canonical QNaN 32'h7FC00000.
- One sub-module: fpu_cmd_fifo (parameterized synchronous FIFO, width 3+32+32+3+TAG_W, depth DEPTH).

Test Plan:
- add 32'h3F800000 + 32'h40000000, rm 0, tag 3 -> rsp_data 32'h40400000, flags 0, tag 3.
- mul 32'h40000000 * 32'h40400000 -> rsp_data 32'h40C00000. Then div 32'h3F800000 / 0 -> rsp_data 32'h7F800000, div_zero=1.
- compare 32'h3F800000 vs 32'h40000000 -> rsp_data 0, less=1, eq=0, great=0. Same operands -> eq=1.
- rsp_ready held 0, push DEPTH+1 commands -> cmd_ready drops after DEPTH+1 accepts (DEPTH queued + 1 held). Release rsp_ready -> responses return in order with tags 0..DEPTH.
- cmd_op=5 -> rsp within 2 cycles, inv=1, fpu_act never asserted. Assert rst during RUN -> busy=0 and no rsp_valid next cycle.
- With FPU_TIMEOUT_EN and fpu_done forced 0 -> rsp_timeout=1 after TIMEOUT RUN cycles, rsp_data 32'h7FC00000.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcodes, flag bit positions, sequencer state encoding and the canonical quiet NaN.
// Flag byte packing is {ov,un,inv,inexact,div_zero,less,eq,great}.
package fpu_pkg;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_SQRT = 3'd3;
    localparam logic [2:0] OP_CMP  = 3'd4;
    localparam int FL_GREAT    = 0;
    localparam int FL_EQ       = 1;
    localparam int FL_LESS     = 2;
    localparam int FL_DIV_ZERO = 3;
    localparam int FL_INEXACT  = 4;
    localparam int FL_INV      = 5;
    localparam int FL_UN       = 6;
    localparam int FL_OV       = 7;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [7:0]  FLAGS_INV = 8'(1 << FL_INV);
    typedef enum logic [1:0] {ST_IDLE, ST_RESET, ST_RUN, ST_HOLD} state_t;
endpackage

// File: rtl/fpu_cmd_seq_if.sv
// fpu_cmd_seq_if: bundles the sequencer's three ports.
//   cmd_*  : tagged request port (valid/ready) from the front end
//   fpu_*  : opcode/act/done initiator port toward the FPU
//   rsp_*  : result/flags/tag response port (valid/ready), plus busy
// Modport master is the sequencer side, slave is the environment side.
interface fpu_cmd_seq_if #(parameter int TAG_W = 4);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [2:0]       cmd_rm;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      fpu_in1;
    logic [31:0]      fpu_in2;
    logic [2:0]       fpu_opcode;
    logic [2:0]       fpu_round_m;
    logic             fpu_rst;
    logic             fpu_act;
    logic [31:0]      fpu_out;
    logic [7:0]       fpu_flags;
    logic             fpu_done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [7:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_timeout;
    logic             busy;
    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rm, cmd_tag,
        output cmd_ready,
        output fpu_in1, fpu_in2, fpu_opcode, fpu_round_m, fpu_rst, fpu_act,
        input  fpu_out, fpu_flags, fpu_done,
        output rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_timeout, busy,
        input  rsp_ready
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rm, cmd_tag,
        input  cmd_ready,
        input  fpu_in1, fpu_in2, fpu_opcode, fpu_round_m, fpu_rst, fpu_act,
        output fpu_out, fpu_flags, fpu_done,
        input  rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_timeout, busy,
        output rsp_ready
    );
endinterface

// File: rtl/fpu_cmd_fifo.sv
// fpu_cmd_fifo: synchronous FIFO holding packed command words.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   i_push   : write i_din (caller guarantees not full)
//   i_pop    : advance head (caller guarantees not empty)
//   o_dout   : head entry, valid whenever o_count != 0
//   o_count  : occupancy 0..DEPTH
module fpu_cmd_fifo #(
    parameter int W     = 74,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_din,
    input  logic                   i_pop,
    output logic [W-1:0]           o_dout,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    always_ff @(posedge clk) if (i_push) r_mem[r_wp] <= i_din;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    assign o_dout  = r_mem[r_rp];
    assign o_count = r_cnt;
endmodule

// File: rtl/fpu_cmd_seq.sv
// fpu_cmd_seq: queues tagged FPU requests and runs each through a reset/activate/done handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fpu_cmd_seq_if.master (cmd_* request, fpu_* FPU initiator, rsp_* response, busy)
// Optional watchdog: define FPU_TIMEOUT_EN to abort a RUN that lasts TIMEOUT cycles.
module fpu_cmd_seq
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    fpu_cmd_seq_if.master bus
);
    localparam int W     = 3 + 32 + 32 + 3 + TAG_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CW    = $clog2(RST_CYC + 1);
    localparam logic [CW-1:0] RC_LAST = CW'(RST_CYC - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RST_CYC < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("fpu_cmd_seq: invalid parameters");
    end

    logic [W-1:0]     w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_push, w_pop, w_empty, w_done, w_to;
    logic [2:0]       w_op, w_rm;
    logic [31:0]      w_a, w_b;
    logic [TAG_W-1:0] w_tag;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_first;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_in1, r_in2;
    logic [2:0]       r_opc, r_rm;
    logic             r_fpu_rst, r_act;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic [7:0]       r_rsp_flags;

    assign w_empty       = w_count == '0;
    assign bus.cmd_ready = w_count != CNT_W'(DEPTH);
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    assign w_pop         = r_state == ST_IDLE && !w_empty;
    assign {w_op, w_a, w_b, w_rm, w_tag} = w_head;

    fpu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_rm, bus.cmd_tag}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    // A done seen in the first RUN cycle may be left over from the previous operation.
    assign w_done = r_state == ST_RUN && !r_first && bus.fpu_done;

`ifdef FPU_TIMEOUT_EN
    localparam int WW = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] r_wd;
    logic          r_to;
    assign w_to            = r_state == ST_RUN && r_wd == WD_LAST && !w_done;
    assign bus.rsp_timeout = r_to;
`else
    assign w_to            = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_first     <= 1'b0;
            r_op        <= '0;
            r_tag       <= '0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_opc       <= '0;
            r_rm        <= '0;
            r_fpu_rst   <= 1'b0;
            r_act       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
`ifdef FPU_TIMEOUT_EN
            r_wd        <= '0;
            r_to        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (!w_empty) begin
                    r_op  <= w_op;
                    r_tag <= w_tag;
                    if (w_op <= OP_CMP) begin
                        r_state   <= ST_RESET;
                        r_cnt     <= '0;
                        r_fpu_rst <= 1'b1;
                        r_in1     <= w_a;
                        r_in2     <= (w_op == OP_SQRT) ? '0 : w_b;
                        r_opc     <= w_op;
                        r_rm      <= w_rm;
                    end else begin
                        // Unknown opcode: answer immediately with invalid, never touch the FPU.
                        r_state     <= ST_HOLD;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_flags <= FLAGS_INV;
                    end
                end
                ST_RESET: if (r_cnt == RC_LAST) begin
                    r_state   <= ST_RUN;
                    r_fpu_rst <= 1'b0;
                    r_act     <= 1'b1;
                    r_first   <= 1'b1;
`ifdef FPU_TIMEOUT_EN
                    r_wd      <= '0;
`endif
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_RUN: begin
                    r_first <= 1'b0;
                    if (w_done || w_to) begin
                        r_state     <= ST_HOLD;
                        r_act       <= 1'b0;
                        r_fpu_rst   <= w_to;
                        r_in1       <= '0;
                        r_in2       <= '0;
                        r_opc       <= '0;
                        r_rm        <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_to ? QNAN : (r_op == OP_CMP) ? '0 : bus.fpu_out;
                        r_rsp_flags <= w_to ? FLAGS_INV : bus.fpu_flags;
`ifdef FPU_TIMEOUT_EN
                        r_to        <= w_to;
                    end else begin
                        r_wd <= r_wd + 1'b1;
`endif
                    end
                end
                ST_HOLD: begin
                    r_fpu_rst <= 1'b0;
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
`ifdef FPU_TIMEOUT_EN
                        r_to        <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.fpu_in1     = r_in1;
    assign bus.fpu_in2     = r_in2;
    assign bus.fpu_opcode  = r_opc;
    assign bus.fpu_round_m = r_rm;
    assign bus.fpu_rst     = r_fpu_rst | rst;
    assign bus.fpu_act     = r_act;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_flags   = r_rsp_flags;
    assign bus.rsp_tag     = r_tag;
    assign bus.busy        = r_state != ST_IDLE || !w_empty;
endmodule

// File: tb/tb_fpu_cmd_seq.sv
// tb_fpu_cmd_seq: directed scoreboard bench for fpu_cmd_seq with a stub FPU.
module tb_fpu_cmd_seq;
    typedef struct {
        logic [31:0] d;
        logic [7:0]  f;
        logic [3:0]  t;
        logic        to;
    } exp_t;

    logic clk, rst;
    int   errors = 0;
    int   checks = 0;
    int   act_cnt = 0;
    int   lat = 3;
    bit   hang = 0;
    logic [7:0] run_cnt;
    exp_t q[$];
    exp_t e;

    fpu_cmd_seq_if #(.TAG_W(4)) bus ();

    fpu_cmd_seq #(.DEPTH(4), .TAG_W(4), .RST_CYC(2), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stub FPU: known vectors return hand-computed IEEE results; anything else returns a^b with inexact.
    // Compare returns a junk result so the sequencer's forced zero is observable.
    function automatic logic [39:0] fpu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 8'h00};
        if (op == 3'd1 && a == 32'h40000000 && b == 32'h40400000) return {32'h40C00000, 8'h00};
        if (op == 3'd2 && a == 32'h3F800000 && b == 32'h0) return {32'h7F800000, 8'h08};
        if (op == 3'd4) return {32'hDEADBEEF, (a == b) ? 8'h02 : 8'h04};
        return {a ^ b, 8'h10};
    endfunction

    always @(posedge clk) begin
        if (bus.fpu_rst) begin
            run_cnt       <= '0;
            bus.fpu_done  <= 1'b0;
            bus.fpu_out   <= '0;
            bus.fpu_flags <= '0;
        end else if (bus.fpu_act && !bus.fpu_done) begin
            run_cnt <= run_cnt + 1'b1;
            if (run_cnt == 8'(lat) && !hang) begin
                bus.fpu_done <= 1'b1;
                {bus.fpu_out, bus.fpu_flags} <= fpu_model(bus.fpu_opcode, bus.fpu_in1, bus.fpu_in2);
            end
        end
    end

    always @(negedge clk) if (bus.fpu_act === 1'b1) act_cnt <= act_cnt + 1;

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got tag %0d data %h, required no response", bus.rsp_tag, bus.rsp_data);
            end else begin
                e = q.pop_front();
                chk("rsp_data", bus.rsp_data, e.d);
                chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.f));
                chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.t));
                chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
                chk("hold_act", 32'(bus.fpu_act), 32'h0);
                chk("hold_in1", bus.fpu_in1, 32'h0);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        input bit want, input logic [31:0] ed, input logic [7:0] ef, input logic eto);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_ready tag %0d: cmd_ready stayed 0, required 1", tag);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_rm    = 3'd0;
        bus.cmd_tag   = tag;
        if (want) q.push_back('{d: ed, f: ef, t: tag, to: eto});
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.busy) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, busy=%b, required 0 and 0", q.size(), bus.busy);
        end
    endtask

    initial begin
        int n;
        int acts;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_rm    = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        chk("rst_fpu_rst", 32'(bus.fpu_rst), 32'h1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_fpu_act", 32'(bus.fpu_act), 32'h0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("run_fpu_rst_low", 32'(bus.fpu_rst), 32'h0);

        send(3'd0, 32'h3F800000, 32'h40000000, 4'd3, 1, 32'h40400000, 8'h00, 0);
        drain();
        send(3'd1, 32'h40000000, 32'h40400000, 4'd1, 1, 32'h40C00000, 8'h00, 0);
        send(3'd2, 32'h3F800000, 32'h00000000, 4'd2, 1, 32'h7F800000, 8'h08, 0);
        drain();
        lat = 0;
        send(3'd4, 32'h3F800000, 32'h40000000, 4'd4, 1, 32'h0, 8'h04, 0);
        send(3'd4, 32'h3F800000, 32'h3F800000, 4'd5, 1, 32'h0, 8'h02, 0);
        drain();

        bus.rsp_ready = 1'b0;
        lat = 1;
        for (int i = 0; i <= 4; i++) begin
            send(3'd0, 32'h1000 + i, 32'h0, i[3:0], 1, 32'h1000 + i, 8'h10, 0);
            if (i == 3) chk("ready_after_4", 32'(bus.cmd_ready), 32'h1);
        end
        chk("ready_after_5", 32'(bus.cmd_ready), 32'h0);
        repeat (20) @(posedge clk);
        #1;
        chk("full_ready", 32'(bus.cmd_ready), 32'h0);
        chk("stall_valid", 32'(bus.rsp_valid), 32'h1);
        chk("stall_tag", 32'(bus.rsp_tag), 32'h0);
        chk("stall_data", bus.rsp_data, 32'h1000);
        bus.rsp_ready = 1'b1;
        drain();

        acts = act_cnt;
        send(3'd5, 32'h1234, 32'h5678, 4'd7, 1, 32'h0, 8'h20, 0);
        n = 0;
        while (!bus.rsp_valid && n < 2) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("op5_rsp_fast", 32'(bus.rsp_valid), 32'h1);
        drain();
        chk("op5_no_act", 32'(act_cnt), 32'(acts));

        hang = 1;
        send(3'd0, 32'h1, 32'h2, 4'd8, 0, 32'h0, 8'h00, 0);
        n = 0;
        while (!bus.fpu_act && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("act_before_rst", 32'(bus.fpu_act), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("midrst_act", 32'(bus.fpu_act), 32'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("post_rst_busy", 32'(bus.busy), 32'h0);
        hang = 0;

`ifdef FPU_TIMEOUT_EN
        hang = 1;
        send(3'd0, 32'h3, 32'h4, 4'd9, 1, 32'h7FC00000, 8'h20, 1);
        drain();
        hang = 0;
`endif
        lat = 2;
        send(3'd0, 32'h3F800000, 32'h40000000, 4'd10, 1, 32'h40400000, 8'h00, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global timeout");
    end
endmodule
